vga_pattern_stream: RTL and testbench
=====================================

# vga_pattern_stream

AXI4-Stream video source producing 640x480 frames of 32-bit pixels (`{8'h00, R[7:0], G[7:0], B[7:0]}`) for the VGA output path. It drives the same stream the VGA controller consumes: `tuser` marks the first pixel of each frame, `tlast` marks the last pixel of each line, and the block fully honors `tready` backpressure. It provides a VDMA-free bring-up and debug source, and a reference stimulus for the display pipeline and CNN input path.

## Interface
Parameters:
- `H_ACTIVE`, 640, pixels per line
- `V_ACTIVE`, 480, lines per frame
- `BAR_WIDTH`, 80, color-bar width in pixels
- `BOX_SIZE`, 32, moving-box edge in pixels
- `BOX_STEP`, 4, box x-advance per frame in pixels

Ports:
- `clk`  in  1  pixel/stream clock. One clock domain only.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  start/continue streaming; sampled only at frame boundaries.
- `pattern_sel`  in  2  0 = color bars, 1 = checkerboard, 2 = moving box, 3 = solid.
- `solid_rgb`  in  24  {R,G,B} used by patterns 2 and 3.
- `m_axis_tdata`  out  32  pixel data.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  last pixel of line (x = H_ACTIVE-1).
- `m_axis_tuser`  out  1  first pixel of frame (x = 0, y = 0).
- `frame_done`  out  1  one-cycle pulse after the last beat of a frame is accepted.
- `frame_cnt`  out  16  count of completed frames; wraps from 0xFFFF to 0.

## Operation
- FSM states:
  - IDLE: `tvalid` = 0.
  - STREAM: `tvalid` = 1.
- IDLE -> STREAM when `enable` = 1.
  - On entry: x = 0, y = 0, `pattern_sel` and `solid_rgb` are latched into the frame registers, and the first beat is presented with `tuser` = 1.
- Handshake = `tvalid & tready`. Counters x (10 bit) and y (9 bit) advance only on a handshake.
  - x wraps H_ACTIVE-1 -> 0 and increments y.
- Last beat of the frame is x = H_ACTIVE-1, y = V_ACTIVE-1. On its handshake:
  - `frame_cnt` increments and `frame_done` pulses.
  - Box position is updated.
  - If `enable` = 1: the next frame's first beat is presented in the next cycle with no gap. `tvalid` stays 1 and the pattern inputs are re-latched.
  - Otherwise the FSM returns to IDLE.
- `enable`, `pattern_sel` and `solid_rgb` changes mid-frame have no effect on the current frame.
- Patterns, computed from the x/y of the beat being presented:
  - 0, color bars: b = x / BAR_WIDTH, clamped to 7. Colors b = 0..7 are FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 1, checkerboard: (x[5] ^ y[5]) ? FFFFFF : 000000.
  - 2, moving box: `solid_rgb` inside [box_x, box_x+BOX_SIZE) x [box_y, box_y+BOX_SIZE), otherwise 000000.
    - box_y is fixed at (V_ACTIVE-BOX_SIZE)/2 = 224.
    - box_x resets to 0 and advances by BOX_STEP per completed frame. If box_x + BOX_STEP + BOX_SIZE > H_ACTIVE, it wraps to 0.
  - 3, solid: `solid_rgb`.
- `tdata[31:24]` is always 0.

## Timing
- Reset (async assert, sync release): state = IDLE. All outputs are 0: `tvalid`, `tdata`, `tlast`, `tuser`, `frame_done`, `frame_cnt`. x = y = box_x = 0.
- All outputs are driven from registers. No combinational path from `tready` to any output.
- Latency: `enable` high in IDLE at edge N -> `tvalid` = 1 with `tuser` = 1 after edge N+1.
- While `tvalid` = 1 and `tready` = 0, `tdata`, `tlast` and `tuser` hold stable for any number of cycles.
- Throughput: 1 beat/cycle with `tready` held high.
  - Back-to-back frames: H_ACTIVE*V_ACTIVE cycles per frame, no bubbles.
- `tready` high while `tvalid` = 0 has no effect.
- `frame_done` is high for exactly the cycle following the final handshake. `frame_cnt` updates in the same cycle.
- Reset asserted mid-frame: outputs clear immediately and the partial frame is abandoned. After release the next frame starts at x = 0, y = 0 with `tuser` = 1.

## Test plan
- Reset, `enable` = 1, `pattern_sel` = 0, `tready` = 1 -> first beat `tdata` = 0x00FFFFFF with `tuser` = 1. Beat x = 80 is 0x00FFFF00 and x = 639 is 0x00000000. `tlast` is set every 640th beat, with 480 `tlast`s per frame. `frame_done` occurs at beat 307200 and `frame_cnt` = 1.
- `pattern_sel` = 1 -> pixel (32,0) = 0x00FFFFFF, (32,32) = 0x00000000. A `pattern_sel` change mid-frame takes effect only at the next `tuser`.
- Random `tready` (50%) -> no beat is lost or duplicated, data/`tlast`/`tuser` are stable while stalled, and the sequence is identical to the always-ready run.
- `pattern_sel` = 2, `solid_rgb` = 0x123456 -> frame 0 box at x 0..31, y 224..255. Frame 1 box at x 4..35. box_x wraps to 0 after reaching 608.
- `enable` dropped mid-frame -> the frame completes, then `tvalid` = 0. With `enable` held high, the next frame's `tuser` follows the last `tlast` with zero idle cycles.
- Assert `reset_n` = 0 at pixel (100,50) -> all outputs 0 asynchronously. After release the stream restarts at (0,0) with `tuser` = 1 and `frame_cnt` = 0.

Source files
------------

// File: rtl/vga_pattern_stream.sv
// -----------------------------------------------------------------------------
// vga_pattern_stream
//
// AXI4-Stream video test-pattern source. Produces H_ACTIVE x V_ACTIVE frames
// of 32-bit pixels {8'h00, R, G, B}. tuser flags the first pixel of a frame,
// tlast flags the last pixel of each line, and tready backpressure is fully
// honoured. Every output comes straight from a register: the pixel for the
// next beat is computed one cycle ahead and loaded on the handshake edge.
//
// Ports:
//   clk            in   pixel/stream clock
//   reset_n        in   asynchronous active-low reset
//   enable         in   start/continue streaming, sampled at frame boundaries
//   pattern_sel    in   0 bars, 1 checkerboard, 2 moving box, 3 solid
//   solid_rgb      in   {R,G,B} colour for patterns 2 and 3
//   m_axis_tdata   out  pixel data
//   m_axis_tvalid  out  beat valid
//   m_axis_tready  in   sink ready
//   m_axis_tlast   out  last pixel of a line
//   m_axis_tuser   out  first pixel of a frame
//   frame_done     out  one-cycle pulse after the final beat of a frame
//   frame_cnt      out  completed-frame counter (wraps)
// -----------------------------------------------------------------------------
module vga_pattern_stream #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int BAR_WIDTH = 80,
   parameter int BOX_SIZE  = 32,
   parameter int BOX_STEP  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_rgb,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
   localparam logic [8:0]  Y_LAST  = 9'(V_ACTIVE - 1);
   localparam logic [8:0]  BOX_Y   = 9'((V_ACTIVE - BOX_SIZE) / 2);
   localparam logic [10:0] BOX_SZ  = 11'(BOX_SIZE);
   localparam logic [10:0] BOX_ADV = 11'(BOX_STEP);
   localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
   localparam logic [9:0]  BAR_W   = 10'(BAR_WIDTH);

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } state_e;

   state_e      state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic [1:0]  pat_q, pat_d;
   logic [23:0] rgb_q, rgb_d;
   logic [9:0]  box_x_q, box_x_d;
   logic [31:0] tdata_q, tdata_d;
   logic        tlast_q, tlast_d;
   logic        tuser_q, tuser_d;
   logic        frame_done_q, frame_done_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        load;
   logic        last_beat;
   logic [10:0] box_adv_sum;

   // Colour of pixel (x, y) for the given frame settings.
   function automatic logic [23:0] pixel_rgb(
      input logic [9:0]  px,
      input logic [8:0]  py,
      input logic [1:0]  sel,
      input logic [23:0] rgb,
      input logic [9:0]  bx
   );
      logic [9:0]  bar;
      logic [10:0] px_e, bx_e, py_e, by_e;
      logic        in_box;
      bar    = px / BAR_W;
      px_e   = {1'b0, px};
      bx_e   = {1'b0, bx};
      py_e   = {2'b00, py};
      by_e   = {2'b00, BOX_Y};
      in_box = (px_e >= bx_e) && (px_e < bx_e + BOX_SZ) &&
               (py_e >= by_e) && (py_e < by_e + BOX_SZ);
      pixel_rgb = 24'h000000;
      case (sel)
         2'd0: begin
            // Bars past the eighth clamp to bar 7, which is black.
            if (bar > 10'd7) begin
               pixel_rgb = 24'h000000;
            end else begin
               case (bar[2:0])
                  3'd0:    pixel_rgb = 24'hFFFFFF;
                  3'd1:    pixel_rgb = 24'hFFFF00;
                  3'd2:    pixel_rgb = 24'h00FFFF;
                  3'd3:    pixel_rgb = 24'h00FF00;
                  3'd4:    pixel_rgb = 24'hFF00FF;
                  3'd5:    pixel_rgb = 24'hFF0000;
                  3'd6:    pixel_rgb = 24'h0000FF;
                  default: pixel_rgb = 24'h000000;
               endcase
            end
         end
         2'd1:    pixel_rgb = (px[5] ^ py[5]) ? 24'hFFFFFF : 24'h000000;
         2'd2:    pixel_rgb = in_box ? rgb : 24'h000000;
         default: pixel_rgb = rgb;
      endcase
   endfunction

   assign last_beat   = (x_q == X_LAST) && (y_q == Y_LAST);
   assign box_adv_sum = {1'b0, box_x_q} + BOX_ADV;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      pat_d        = pat_q;
      rgb_d        = rgb_q;
      box_x_d      = box_x_q;
      tdata_d      = tdata_q;
      tlast_d      = tlast_q;
      tuser_d      = tuser_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      load         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_STREAM;
               x_d     = 10'd0;
               y_d     = 9'd0;
               pat_d   = pattern_sel;
               rgb_d   = solid_rgb;
               load    = 1'b1;
            end
         end
         ST_STREAM: begin
            // tvalid is 1 in this state, so tready alone is the handshake.
            if (m_axis_tready) begin
               if (last_beat) begin
                  frame_cnt_d  = frame_cnt_q + 16'd1;
                  frame_done_d = 1'b1;
                  box_x_d      = (box_adv_sum + BOX_SZ > H_LIM) ? 10'd0 : box_adv_sum[9:0];
                  x_d          = 10'd0;
                  y_d          = 9'd0;
                  if (enable) begin
                     // Gapless restart: next frame uses freshly latched settings
                     // and the already-advanced box position.
                     pat_d = pattern_sel;
                     rgb_d = solid_rgb;
                     load  = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     tdata_d = 32'h0;
                     tlast_d = 1'b0;
                     tuser_d = 1'b0;
                  end
               end else begin
                  if (x_q == X_LAST) begin
                     x_d = 10'd0;
                     y_d = y_q + 9'd1;
                  end else begin
                     x_d = x_q + 10'd1;
                  end
                  load = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         tdata_d = {8'h00, pixel_rgb(x_d, y_d, pat_d, rgb_d, box_x_d)};
         tlast_d = (x_d == X_LAST);
         tuser_d = (x_d == 10'd0) && (y_d == 9'd0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         x_q          <= 10'd0;
         y_q          <= 9'd0;
         pat_q        <= 2'd0;
         rgb_q        <= 24'h0;
         box_x_q      <= 10'd0;
         tdata_q      <= 32'h0;
         tlast_q      <= 1'b0;
         tuser_q      <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         pat_q        <= pat_d;
         rgb_q        <= rgb_d;
         box_x_q      <= box_x_d;
         tdata_q      <= tdata_d;
         tlast_q      <= tlast_d;
         tuser_q      <= tuser_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign m_axis_tvalid = (state_q == ST_STREAM);
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign frame_done    = frame_done_q;
   assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_stream.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_stream
//
// Directed bench for vga_pattern_stream on a reduced 64x40 raster. Expected
// beats for each frame are queued when the frame is set up and compared in
// order as the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_vga_pattern_stream;

   localparam int H     = 64;
   localparam int V     = 40;
   localparam int BAR   = 6;
   localparam int BOX   = 8;
   localparam int STEP  = 8;
   localparam int BOX_Y = (V - BOX) / 2;
   localparam int FRAME = H * V;
   localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        user;
      logic        eof;
      logic        gapless;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic [23:0] solid_rgb;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        tuser;
   logic        frame_done;
   logic [15:0] frame_cnt;

   int          checks = 0;
   int          errors = 0;
   beat_t       sb[$];
   beat_t       mon_e;
   int          box_push = 0;
   int          fcnt_model = 0;
   logic        rand_rdy = 1'b0;
   logic        rdy_fixed = 1'b0;
   logic        done_pend = 1'b0;
   logic        eof_pend = 1'b0;
   logic        gap_exp = 1'b0;
   logic        stall_pend = 1'b0;
   logic [33:0] held = '0;

   vga_pattern_stream #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .BAR_WIDTH(BAR),
      .BOX_SIZE (BOX),
      .BOX_STEP (STEP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .pattern_sel  (pattern_sel),
      .solid_rgb    (solid_rgb),
      .m_axis_tdata (tdata),
      .m_axis_tvalid(tvalid),
      .m_axis_tready(tready),
      .m_axis_tlast (tlast),
      .m_axis_tuser (tuser),
      .frame_done   (frame_done),
      .frame_cnt    (frame_cnt)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] ref_pix(input int x, input int y, input int p,
                                           input logic [23:0] rgb, input int bx);
      int b;
      case (p)
         0: begin
            b = x / BAR;
            if (b > 7) b = 7;
            return BARS[b];
         end
         1: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
         2: return (x >= bx && x < bx + BOX && y >= BOX_Y && y < BOX_Y + BOX) ? rgb : 24'h000000;
         default: return rgb;
      endcase
   endfunction

   task automatic push_frame(input int p, input logic [23:0] rgb, input logic gapless);
      beat_t e;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            e.data    = {8'h00, ref_pix(x, y, p, rgb, box_push)};
            e.last    = (x == H - 1);
            e.user    = (x == 0 && y == 0);
            e.eof     = (x == H - 1 && y == V - 1);
            e.gapless = gapless;
            sb.push_back(e);
         end
      end
      if (box_push + STEP + BOX > H) box_push = 0;
      else box_push = box_push + STEP;
   endtask

   task automatic wait_q(input int n, input int budget);
      int i;
      i = 0;
      while (sb.size() > n && i < budget) begin
         @(posedge clk);
         i++;
      end
      check("wait_progress", 64'(sb.size() <= n), 64'd1);
   endtask

   // Ready generator: fixed level or 50% random, changed just after each edge.
   initial begin
      tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
      end
   end

   // Monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (!reset_n) begin
         done_pend  = 1'b0;
         eof_pend   = 1'b0;
         stall_pend = 1'b0;
         fcnt_model = 0;
      end else begin
         check("frame_done", 64'(frame_done), 64'(done_pend));
         if (done_pend) check("frame_cnt", 64'(frame_cnt), 64'(fcnt_model));
         if (eof_pend) begin
            check("post_frame_tvalid", 64'(tvalid), 64'(gap_exp));
            if (gap_exp) check("post_frame_tuser", 64'(tuser), 64'd1);
         end
         if (stall_pend) check("stall_hold", 64'({tvalid, tuser, tlast, tdata}), 64'({1'b1, held}));
         done_pend  = 1'b0;
         eof_pend   = 1'b0;
         stall_pend = 1'b0;
         if (tvalid && tready) begin
            check("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               check("beat", 64'({tuser, tlast, tdata}), 64'({mon_e.user, mon_e.last, mon_e.data}));
               if (mon_e.eof) begin
                  fcnt_model = fcnt_model + 1;
                  done_pend  = 1'b1;
                  eof_pend   = 1'b1;
                  gap_exp    = mon_e.gapless;
               end
            end
         end else if (tvalid) begin
            stall_pend = 1'b1;
            held       = {tuser, tlast, tdata};
         end
      end
   end

   initial begin
      reset_n     = 1'b0;
      enable      = 1'b0;
      pattern_sel = 2'd0;
      solid_rgb   = 24'h0;
      repeat (3) @(negedge clk);
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_tdata", 64'(tdata), 64'd0);
      check("rst_tlast", 64'(tlast), 64'd0);
      check("rst_tuser", 64'(tuser), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      reset_n   = 1'b1;
      rdy_fixed = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_ready_no_effect", 64'(tvalid), 64'd0);
      check("idle_frame_cnt", 64'(frame_cnt), 64'd0);

      // Frame A: colour bars, first-beat latency.
      @(posedge clk);
      #1;
      enable = 1'b1;
      push_frame(0, 24'h0, 1'b1);
      @(negedge clk);
      check("latency_pre", 64'(tvalid), 64'd0);
      @(negedge clk);
      check("latency_tvalid", 64'(tvalid), 64'd1);
      check("first_tuser", 64'(tuser), 64'd1);
      check("first_tdata", 64'(tdata), 64'h00FFFFFF);

      // Frame B: checkerboard, selected mid-frame A.
      wait_q(1500, 20000);
      pattern_sel = 2'd1;
      push_frame(1, 24'h0, 1'b1);

      // Frames C, D: moving box under random backpressure.
      wait_q(1500, 20000);
      pattern_sel = 2'd2;
      solid_rgb   = 24'h123456;
      rand_rdy    = 1'b1;
      push_frame(2, 24'h123456, 1'b1);
      push_frame(2, 24'h123456, 1'b1);

      // Frames E..I: box walks to the right edge and wraps; enable drops in I.
      wait_q(1500, 40000);
      rand_rdy = 1'b0;
      for (int f = 0; f < 4; f++) push_frame(2, 24'h123456, 1'b1);
      push_frame(2, 24'h123456, 1'b0);
      wait_q(1500, 40000);
      enable = 1'b0;
      wait_q(0, 5000);
      repeat (3) @(negedge clk);
      check("idle_after_drop", 64'(tvalid), 64'd0);
      check("frame_cnt_after_9", 64'(frame_cnt), 64'd9);

      // Frame J: solid colour, abandoned by reset near pixel (30,20).
      pattern_sel = 2'd3;
      solid_rgb   = 24'hA5C3E1;
      enable      = 1'b1;
      push_frame(3, 24'hA5C3E1, 1'b1);
      wait_q(FRAME - (20 * H + 30), 10000);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_tvalid", 64'(tvalid), 64'd0);
      check("async_rst_tdata", 64'(tdata), 64'd0);
      check("async_rst_tlast", 64'(tlast), 64'd0);
      check("async_rst_tuser", 64'(tuser), 64'd0);
      check("async_rst_frame_done", 64'(frame_done), 64'd0);
      check("async_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      sb.delete();
      box_push    = 0;
      pattern_sel = 2'd0;
      solid_rgb   = 24'h0;
      repeat (2) @(negedge clk);

      // Frame K: restart after reset, single frame.
      push_frame(0, 24'h0, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      check("restart_tvalid", 64'(tvalid), 64'd1);
      check("restart_tuser", 64'(tuser), 64'd1);
      check("restart_frame_cnt", 64'(frame_cnt), 64'd0);
      wait_q(1500, 20000);
      enable = 1'b0;
      wait_q(0, 5000);
      repeat (3) @(negedge clk);
      check("final_frame_cnt", 64'(frame_cnt), 64'd1);
      check("final_idle", 64'(tvalid), 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
